// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider controller.
package div_pkg;

  // Controller states; the encoding is fixed so checkers can bind to it.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  // Function-unit select width and the subtract code it decodes.
  localparam int              FS_W       = 5;
  localparam logic [FS_W-1:0] FS_SUB_DEF = 5'b00101;

endpackage

// File: rtl/div_negate.sv
// Conditional two's-complement: passes the input through, or negates it when en is set.
module div_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  assign out = en ? (~in + W'(1)) : in;

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider controller. One trial subtraction per RUN
// cycle is delegated to an external function unit via the fu_* ports.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; req_ready is high only in IDLE, resp_valid holds with stable
// data until resp_ready is seen.
module div_sequencer
  import div_pkg::*;
#(
  parameter int              BITS   = 32,
  parameter logic [FS_W-1:0] FS_SUB = FS_SUB_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_signed,
  input  logic [BITS-1:0] req_dividend,
  input  logic [BITS-1:0] req_divisor,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [BITS-1:0] resp_quot,
  output logic [BITS-1:0] resp_rem,
  output logic            resp_div0,
  output logic [BITS-1:0] fu_a,
  output logic [BITS-1:0] fu_b,
  output logic [FS_W-1:0] fu_fs,
  output logic [4:0]      fu_sh,
  input  logic [BITS-1:0] fu_out,
  input  logic            fu_c
);

  localparam int CW = $clog2(BITS);

  div_state_t      r_state;
  div_state_t      w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [BITS-1:0] r_dvd;     // dividend magnitude; quotient bits shift in from the bottom
  logic [BITS-1:0] r_dvs;     // divisor magnitude
  logic [BITS-1:0] r_rem;     // partial remainder
  logic            r_neg_q;
  logic            r_neg_r;
  logic [BITS-1:0] r_quot;
  logic [BITS-1:0] r_rem_out;
  logic            r_div0;
  logic            r_resp_valid;

  logic [BITS-1:0] w_dvd_mag;
  logic [BITS-1:0] w_dvs_mag;
  logic [BITS-1:0] w_quot_fix;
  logic [BITS-1:0] w_rem_fix;
  logic [BITS:0]   w_rp;      // shifted remainder, one bit wider than the operands
  logic            w_qb;
  logic            w_accept;
  logic            w_dvs_zero;

  // Operand magnitudes at accept time, and sign fix-up of the finished result.
  div_negate #(.W(BITS)) u_neg_dvd (
    .en  (req_signed & req_dividend[BITS-1]),
    .in  (req_dividend),
    .out (w_dvd_mag)
  );
  div_negate #(.W(BITS)) u_neg_dvs (
    .en  (req_signed & req_divisor[BITS-1]),
    .in  (req_divisor),
    .out (w_dvs_mag)
  );
  div_negate #(.W(BITS)) u_neg_quot (
    .en  (r_neg_q),
    .in  (r_dvd),
    .out (w_quot_fix)
  );
  div_negate #(.W(BITS)) u_neg_rem (
    .en  (r_neg_r),
    .in  (r_rem),
    .out (w_rem_fix)
  );

  // When the shifted-out top bit is set the remainder already exceeds any
  // divisor, so the bit forces a subtract and the mod-2^BITS difference is exact.
  assign w_rp       = {r_rem, r_dvd[BITS-1]};
  assign w_qb       = w_rp[BITS] | fu_c;
  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_dvs_zero = (req_divisor == '0);

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_quot  = r_quot;
  assign resp_rem   = r_rem_out;
  assign resp_div0  = r_div0;
  assign fu_fs      = FS_SUB;
  assign fu_sh      = 5'd0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and function-unit operand drive.
  always_comb begin
    w_state_nxt = r_state;
    fu_a        = '0;
    fu_b        = '0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_dvs_zero ? S_DONE : S_RUN;
      S_RUN: begin
        fu_a = w_rp[BITS-1:0];
        fu_b = r_dvs;
        if (r_cnt == '0) w_state_nxt = S_FIX;
      end
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: if (r_resp_valid && resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix and response registers.
  // resp_valid rises one cycle into DONE so the result is presented registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_dvd        <= '0;
      r_dvs        <= '0;
      r_rem        <= '0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_quot       <= '0;
      r_rem_out    <= '0;
      r_div0       <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_neg_q <= req_signed & (req_dividend[BITS-1] ^ req_divisor[BITS-1]);
            r_neg_r <= req_signed & req_dividend[BITS-1];
            r_dvd   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_rem   <= '0;
            r_cnt   <= CW'(BITS - 1);
            r_div0  <= w_dvs_zero;
            if (w_dvs_zero) begin
              r_quot    <= '1;
              r_rem_out <= req_dividend;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_qb ? fu_out : w_rp[BITS-1:0];
          r_dvd <= {r_dvd[BITS-2:0], w_qb};
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_quot    <= w_quot_fix;
          r_rem_out <= w_rem_fix;
        end
        S_DONE: begin
          if (!r_resp_valid)   r_resp_valid <= 1'b1;
          else if (resp_ready) r_resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer with a behavioural subtract function unit attached.
module tb_div_sequencer;

  localparam int BITS = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_signed = 1'b0;
  logic [BITS-1:0] req_dividend = '0;
  logic [BITS-1:0] req_divisor = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [BITS-1:0] resp_quot;
  logic [BITS-1:0] resp_rem;
  logic            resp_div0;
  logic [BITS-1:0] fu_a;
  logic [BITS-1:0] fu_b;
  logic [4:0]      fu_fs;
  logic [4:0]      fu_sh;
  logic [BITS-1:0] fu_out;
  logic            fu_c;

  int n_tests = 0;
  int n_fail  = 0;

  div_sequencer #(.BITS(BITS), .FS_SUB(5'b00101)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_signed   (req_signed),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_quot    (resp_quot),
    .resp_rem     (resp_rem),
    .resp_div0    (resp_div0),
    .fu_a         (fu_a),
    .fu_b         (fu_b),
    .fu_fs        (fu_fs),
    .fu_sh        (fu_sh),
    .fu_out       (fu_out),
    .fu_c         (fu_c)
  );

  // Function unit: subtract with no-borrow carry when selected.
  assign fu_out = (fu_fs == 5'b00101) ? (fu_a - fu_b) : '0;
  assign fu_c   = (fu_fs == 5'b00101) ? (fu_a >= fu_b) : 1'b0;

  // Clock.
  always #5 clk = ~clk;

  typedef struct {
    bit              sgn;
    logic [BITS-1:0] dvd;
    logic [BITS-1:0] dvs;
    logic [BITS-1:0] q;
    logic [BITS-1:0] r;
    logic            d0;
    int              lat;
  } vec_t;

  task automatic check(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: magnitude division with plain wide arithmetic, then sign rules.
  task automatic model(input bit s, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                       output logic [BITS-1:0] q, output logic [BITS-1:0] r, output logic d0);
    logic [63:0] ma, mb, mq, mr;
    if (b == '0) begin
      q = '1; r = a; d0 = 1'b1;
    end else begin
      ma = (s && a[BITS-1]) ? (64'h1_0000_0000 - {32'b0, a}) : {32'b0, a};
      mb = (s && b[BITS-1]) ? (64'h1_0000_0000 - {32'b0, b}) : {32'b0, b};
      mq = ma / mb;
      mr = ma % mb;
      q  = (s && (a[BITS-1] ^ b[BITS-1])) ? (32'h0 - mq[31:0]) : mq[31:0];
      r  = (s && a[BITS-1]) ? (32'h0 - mr[31:0]) : mr[31:0];
      d0 = 1'b0;
    end
  endtask

  // Driver: present a request, let it be accepted on the next edge.
  task automatic start_req(input bit s, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    @(negedge clk);
    req_signed = s; req_dividend = a; req_divisor = b; req_valid = 1'b1;
    check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Count edges after accept until resp_valid is seen, with a cycle budget.
  task automatic wait_resp(output int lat);
    bit got = 1'b0;
    lat = 0;
    while (!got && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      got = resp_valid;
    end
    if (!got) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    start_req(v.sgn, v.dvd, v.dvs);
    wait_resp(lat);
    check({tag, "_quot"}, resp_quot, v.q);
    check({tag, "_rem"},  resp_rem,  v.r);
    check({tag, "_div0"}, {31'b0, resp_div0}, {31'b0, v.d0});
    check({tag, "_lat"},  lat, v.lat);
    @(posedge clk);
    #1 check({tag, "_handshake"}, {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  {31'b0, req_ready},  32'd1);
    check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_quot"},       resp_quot, 32'd0);
    check({tag, "_rem"},        resp_rem,  32'd0);
    check({tag, "_div0"},       {31'b0, resp_div0}, 32'd0);
    check({tag, "_fu_a"},       fu_a, 32'd0);
    check({tag, "_fu_b"},       fu_b, 32'd0);
    check({tag, "_fu_fs"},      {27'b0, fu_fs}, 32'd5);
    check({tag, "_fu_sh"},      {27'b0, fu_sh}, 32'd0);
  endtask

  // Scoreboard queues for the randomized phase.
  logic [BITS-1:0] exp_q[$];
  logic [BITS-1:0] exp_r[$];

  initial begin
    vec_t vecs[11];
    vecs[0]  = '{0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
    vecs[1]  = '{1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 34};
    vecs[2]  = '{1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 34};
    vecs[3]  = '{0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1};
    vecs[4]  = '{1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34};
    vecs[5]  = '{0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 34};
    vecs[6]  = '{0, 32'hFFFFFFFF,   32'h80000001,   32'd1,          32'h7FFFFFFE,   1'b0, 34};
    vecs[7]  = '{1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1, 1};
    vecs[8]  = '{0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0, 34};
    vecs[9]  = '{1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 34};
    vecs[10] = '{0, 32'd3,          32'd5,          32'd0,          32'd3,          1'b0, 34};

    // Reset values.
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Hold in DONE with resp_ready low; requests presented meanwhile are ignored.
    begin
      int lat;
      resp_ready = 1'b0;
      start_req(1'b0, 32'd100, 32'd7);
      wait_resp(lat);
      check("hold_lat", lat, 34);
      req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd1; req_divisor = 32'd1;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk);
        #1;
        check("hold_valid", {31'b0, resp_valid}, 32'd1);
        check("hold_quot",  resp_quot, 32'd14);
        check("hold_rem",   resp_rem,  32'd2);
        check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      end
      req_dividend = 32'd13; req_divisor = 32'd4;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("after_hs_valid",     {31'b0, resp_valid}, 32'd0);
      check("after_hs_req_ready", {31'b0, req_ready},  32'd1);
      @(posedge clk);
      #1;
      check("next_accepted", {31'b0, req_ready}, 32'd0);
      req_valid = 1'b0;
      wait_resp(lat);
      check("next_lat",  lat, 34);
      check("next_quot", resp_quot, 32'd3);
      check("next_rem",  resp_rem,  32'd1);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of RUN.
    start_req(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("post_reset", vecs[0]);

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 30; i++) begin
      bit              s;
      logic [BITS-1:0] a, b, q, r;
      logic            d0;
      int              lat;
      int              mode;
      s    = 1'($urandom_range(0, 1));
      a    = $urandom;
      mode = $urandom_range(0, 4);
      if (mode == 0)      b = '0;
      else if (mode == 1) b = $urandom_range(1, 20);
      else if (mode == 2) b = 32'h0 - $urandom_range(1, 20);
      else                b = $urandom;
      model(s, a, b, q, r, d0);
      exp_q.push_back(q);
      exp_r.push_back(r);
      start_req(s, a, b);
      wait_resp(lat);
      check("rand_quot", resp_quot, exp_q.pop_front());
      check("rand_rem",  resp_rem,  exp_r.pop_front());
      check("rand_div0", {31'b0, resp_div0}, {31'b0, d0});
      check("rand_lat",  lat, d0 ? 1 : 34);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
